// File: rtl/am29_intack_pkg.sv
// Shared constants, state encoding and helpers for the am2913 acknowledge-side
// interrupt controller.
package am29_intack_pkg;

    localparam int NLEVELS = 8;
    localparam int VW      = 3;

    // IDLE: no request latched, irq_ high.
    // REQ:  a vector is latched and irq_ is low, waiting for ack.
    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    // Decode a level number into its one-hot position in an 8-bit level vector.
    function automatic logic [NLEVELS-1:0] onehot8(input logic [VW-1:0] lvl);
        onehot8 = {{(NLEVELS-1){1'b0}}, 1'b1} << lvl;
    endfunction

endpackage

// File: rtl/am29_intack_pri8.sv
// Combinational 8-to-3 highest-set-bit finder. It reports the index of the
// most significant set bit of the input. The none flag is raised when no bit
// is set, and in that case the index output is 0.
module am29_pri8
    import am29_intack_pkg::*;
(
    input  logic [NLEVELS-1:0] isr,
    output logic [VW-1:0]      cur,
    output logic               none
);

    // Scan upward so the last set bit found, which is the highest, wins.
    always_comb begin
        cur  = '0;
        none = 1'b1;
        for (int i = 0; i < NLEVELS; i++) begin
            if (isr[i]) begin
                cur  = VW'(i);
                none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/am29_intack.sv
// Acknowledge-side controller for the am2913 priority encoder. It takes the
// encoded request from the expander and filters it through the mask register
// and the nested-priority rule, where only a level above the highest one in
// service may interrupt. It raises irq_, latches the vector, and tracks the
// in-service levels through ack and EOI. On ack it pulses the matching clr_ bit
// low for one cycle. All outputs are registered.
module am29_intack
    import am29_intack_pkg::*;
(
    input  logic                clk,
    input  logic                rst_,
    input  logic [VW-1:0]       a,
    input  logic                gs_,
    input  logic                ack,
    input  logic                eoi,
    input  logic                mask_we,
    input  logic [NLEVELS-1:0]  mask_d,
    output logic                irq_,
    output logic [VW-1:0]       vec,
    output logic [NLEVELS-1:0]  isr,
    output logic [NLEVELS-1:0]  mask,
    output logic [NLEVELS-1:0]  clr_
);

    state_t               state, state_nx;
    logic [VW-1:0]        vec_nx;
    logic                 irq_nx;
    logic [NLEVELS-1:0]   isr_nx;
    logic [NLEVELS-1:0]   clr_nx;
    logic [VW-1:0]        cur;
    logic                 none;
    logic                 elig;

    am29_pri8 u_pri8 (
        .isr  (isr),
        .cur  (cur),
        .none (none)
    );

    // A request may interrupt when it is present, unmasked, and either nothing
    // is in service or it outranks the highest level in service.
    assign elig = !gs_ && !mask[a] && (none || (a > cur));

    // Next-state and output decode. EOI retires the current top level first,
    // so an ack in the same cycle ORs its level into the already-cleared isr.
    always_comb begin
        state_nx = state;
        vec_nx   = vec;
        irq_nx   = irq_;
        isr_nx   = isr;
        clr_nx   = '1;

        if (eoi && !none) begin
            isr_nx = isr & ~onehot8(cur);
        end

        case (state)
            IDLE: begin
                if (elig) begin
                    vec_nx   = a;
                    irq_nx   = 1'b0;
                    state_nx = REQ;
                end
            end
            REQ: begin
                if (ack) begin
                    isr_nx   = isr_nx | onehot8(vec);
                    clr_nx   = ~onehot8(vec);
                    irq_nx   = 1'b1;
                    state_nx = IDLE;
                end else if (elig) begin
                    // A higher arriving level replaces the latched one.
                    vec_nx   = a;
                end else begin
                    // The request was withdrawn or masked. Drop it without
                    // a clear pulse.
                    irq_nx   = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: begin
                irq_nx   = 1'b1;
                state_nx = IDLE;
            end
        endcase
    end

    // Control state and registered outputs. Reset drops any pending request
    // and any in-service levels without issuing a clear pulse.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            state <= IDLE;
            irq_  <= 1'b1;
            vec   <= '0;
            isr   <= '0;
            clr_  <= '1;
        end else begin
            state <= state_nx;
            irq_  <= irq_nx;
            vec   <= vec_nx;
            isr   <= isr_nx;
            clr_  <= clr_nx;
        end
    end

    // Mask register. A write affects eligibility from the following cycle.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            mask <= '1;
        end else if (mask_we) begin
            mask <= mask_d;
        end
    end

endmodule
